// File: rtl/regfile_port_controller_if.sv
// Request/response bundle between a requester and the register-file port controller.
interface regfile_port_controller_if #(
  parameter int unsigned WORDSIZE = 64
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [4:0]          req_addr_a;
  logic [4:0]          req_addr_b;
  logic [WORDSIZE-1:0] req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORDSIZE-1:0] rsp_data_a;
  logic [WORDSIZE-1:0] rsp_data_b;

  modport master (
    output req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/regfile_port_controller.sv
// Front end owning the register file's write port and read-address ports:
// clears the file after reset, then serves read-pair / write requests.
module regfile_port_controller #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned SIZE     = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_port_controller_if.slave bus,
  output logic                init_done_o,
  output logic                rf_write_en_o,
  output logic [4:0]          rf_write_addr_o,
  output logic [WORDSIZE-1:0] rf_write_data_o,
  output logic [4:0]          rf_addr_a_o,
  output logic [4:0]          rf_addr_b_o,
  input  logic [WORDSIZE-1:0] rf_data_a_i,
  input  logic [WORDSIZE-1:0] rf_data_b_i
);

  typedef enum logic [1:0] {INIT, IDLE, READ, RESP} state_t;

  localparam logic [5:0] CLR_END = 6'(SIZE);

  state_t              state_q;
  logic [5:0]          clr_cnt_q;
  logic                init_done_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [WORDSIZE-1:0] rsp_data_a_q;
  logic [WORDSIZE-1:0] rsp_data_b_q;
  logic                rf_we_q;
  logic [4:0]          rf_waddr_q;
  logic [WORDSIZE-1:0] rf_wdata_q;
  logic [4:0]          rf_addr_a_q;
  logic [4:0]          rf_addr_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      clr_cnt_q    <= '0;
      init_done_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_addr_a_q  <= '0;
      rf_addr_b_q  <= '0;
    end else begin
      rf_we_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          // Counter runs one past the last address so the final edge retires the clear.
          if (clr_cnt_q == CLR_END) begin
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= clr_cnt_q[4:0];
            rf_wdata_q <= '0;
            clr_cnt_q  <= clr_cnt_q + 6'd1;
          end
        end
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_write) begin
              rf_we_q    <= !(ZERO_REG && (bus.req_addr_a == 5'd0));
              rf_waddr_q <= bus.req_addr_a;
              rf_wdata_q <= bus.req_wdata;
            end else begin
              rf_addr_a_q <= bus.req_addr_a;
              rf_addr_b_q <= bus.req_addr_b;
              req_ready_q <= 1'b0;
              state_q     <= READ;
            end
          end
        end
        READ: begin
          rsp_data_a_q <= (ZERO_REG && (rf_addr_a_q == 5'd0)) ? '0 : rf_data_a_i;
          rsp_data_b_q <= (ZERO_REG && (rf_addr_b_q == 5'd0)) ? '0 : rf_data_b_i;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data_a = rsp_data_a_q;
  assign bus.rsp_data_b = rsp_data_b_q;

  assign init_done_o     = init_done_q;
  assign rf_write_en_o   = rf_we_q;
  assign rf_write_addr_o = rf_waddr_q;
  assign rf_write_data_o = rf_wdata_q;
  assign rf_addr_a_o     = rf_addr_a_q;
  assign rf_addr_b_o     = rf_addr_b_q;

endmodule

// File: tb/tb_regfile_port_controller.sv
// Self-checking bench for regfile_port_controller with a behavioural 32x64 register file.
module tb_regfile_port_controller;

  localparam int unsigned WS   = 64;
  localparam int unsigned NREG = 32;
  localparam bit          ZR   = 1'b1;

  logic          clk;
  logic          rst;
  logic          init_done;
  logic          rf_write_en;
  logic [4:0]    rf_write_addr;
  logic [WS-1:0] rf_write_data;
  logic [4:0]    rf_addr_a;
  logic [4:0]    rf_addr_b;
  logic [WS-1:0] rf_data_a;
  logic [WS-1:0] rf_data_b;

  logic [WS-1:0] rf_mem  [NREG];
  logic [WS-1:0] exp_mem [NREG];
  logic [WS-1:0] exp_a_q [$];
  logic [WS-1:0] exp_b_q [$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  regfile_port_controller_if #(.WORDSIZE(WS)) bus ();

  regfile_port_controller #(
    .WORDSIZE(WS),
    .SIZE    (NREG),
    .ZERO_REG(ZR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .init_done_o    (init_done),
    .rf_write_en_o  (rf_write_en),
    .rf_write_addr_o(rf_write_addr),
    .rf_write_data_o(rf_write_data),
    .rf_addr_a_o    (rf_addr_a),
    .rf_addr_b_o    (rf_addr_b),
    .rf_data_a_i    (rf_data_a),
    .rf_data_b_i    (rf_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, commit on rising edge.
  assign rf_data_a = rf_mem[rf_addr_a];
  assign rf_data_b = rf_mem[rf_addr_b];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;

  task automatic check_eq(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: compares each handshaken response against the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_a_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        check_eq("rsp_data_a", bus.rsp_data_a, exp_a_q.pop_front());
        check_eq("rsp_data_b", bus.rsp_data_b, exp_b_q.pop_front());
      end
    end
  end

  task automatic reset_and_init();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int i = 0; i < int'(NREG); i++) exp_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    check_eq("rst_we",        64'(rf_write_en), 64'd0);
    check_eq("rst_waddr",     64'(rf_write_addr), 64'd0);
    check_eq("rst_wdata",     rf_write_data, 64'd0);
    check_eq("rst_addr_ab",   64'({rf_addr_a, rf_addr_b}), 64'd0);
    check_eq("rst_rsp_data",  bus.rsp_data_a | bus.rsp_data_b, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      @(posedge clk);
      #1;
      check_eq("init_we",    64'(rf_write_en), 64'd1);
      check_eq("init_waddr", 64'(rf_write_addr), 64'(i));
      check_eq("init_wdata", rf_write_data, 64'd0);
      check_eq("init_ready", 64'({init_done, bus.req_ready}), 64'd0);
    end
    @(posedge clk);
    #1;
    check_eq("init_we_end",   64'(rf_write_en), 64'd0);
    check_eq("init_done",     64'(init_done), 64'd1);
    check_eq("init_req_rdy",  64'(bus.req_ready), 64'd1);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic wr, input logic [4:0] a, input logic [4:0] b,
                      input logic [WS-1:0] d);
    int unsigned k = 0;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_wdata  = d;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      check_eq("req_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (wr) begin
      if (!(ZR && a == 5'd0)) exp_mem[a] = d;
    end else begin
      exp_a_q.push_back((ZR && a == 5'd0) ? '0 : exp_mem[a]);
      exp_b_q.push_back((ZR && b == 5'd0) ? '0 : exp_mem[b]);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (wr) begin
      check_eq("wr_we", 64'(rf_write_en), (ZR && a == 5'd0) ? 64'd0 : 64'd1);
      if (!(ZR && a == 5'd0)) begin
        check_eq("wr_addr", 64'(rf_write_addr), 64'(a));
        check_eq("wr_data", rf_write_data, d);
      end
    end
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (exp_a_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("rsp_drain", 64'(exp_a_q.size()), 64'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr_a = '0;
    bus.req_addr_b = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < int'(NREG); i++) rf_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);

    reset_and_init();

    // Write then read-after-write with latency check
    send(1'b1, 5'd5, 5'd0, 64'hDEADBEEF_CAFEF00D);
    send(1'b0, 5'd5, 5'd7, '0);
    check_eq("rd_lat_n1", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check_eq("rd_lat_n2", 64'(bus.rsp_valid), 64'd1);
    drain();

    // Backpressure on the response channel
    bus.rsp_ready = 1'b0;
    send(1'b0, 5'd7, 5'd5, '0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid",  64'(bus.rsp_valid), 64'd1);
      check_eq("bp_data_a", bus.rsp_data_a, 64'd0);
      check_eq("bp_data_b", bus.rsp_data_b, 64'hDEADBEEF_CAFEF00D);
      check_eq("bp_ready",  64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_req_ready_after", 64'(bus.req_ready), 64'd1);
    check_eq("bp_valid_after",     64'(bus.rsp_valid), 64'd0);
    drain();

    // Zero register: write suppressed, reads masked even if the file holds junk
    send(1'b1, 5'd0, 5'd0, 64'h1);
    rf_mem[0] = 64'h1234_5678_9ABC_DEF0;
    send(1'b0, 5'd0, 5'd0, '0);
    drain();

    // Back-to-back writes
    send(1'b1, 5'd1, 5'd0, 64'h11);
    send(1'b1, 5'd2, 5'd0, 64'h22);
    send(1'b1, 5'd3, 5'd0, 64'h33);
    send(1'b0, 5'd3, 5'd1, '0);
    drain();

    // Async reset with a response pending
    bus.rsp_ready = 1'b0;
    send(1'b0, 5'd2, 5'd3, '0);
    @(negedge clk);
    check_eq("ar_pre_valid", 64'(bus.rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("ar_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("ar_init_done", 64'(init_done), 64'd0);
    check_eq("ar_we",        64'(rf_write_en), 64'd0);
    bus.rsp_ready = 1'b1;
    reset_and_init();
    send(1'b0, 5'd5, 5'd2, '0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
